// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_ctrl_pkg
// Brief    : Shared opcodes, state encoding, instruction classes and ALU-op
//            codes for the RV64-subset multi-cycle controller.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

  localparam int OPC_WIDTH = 7;

  localparam logic [6:0] OPC_RTYPE = 7'd51;
  localparam logic [6:0] OPC_LD    = 7'd3;
  localparam logic [6:0] OPC_ADDI  = 7'd19;
  localparam logic [6:0] OPC_SD    = 7'd35;
  localparam logic [6:0] OPC_BR    = 7'd99;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,
    CLS_R    = 3'd1,
    CLS_LD   = 3'd2,
    CLS_ADDI = 3'd3,
    CLS_SD   = 3'd4,
    CLS_BR   = 3'd5,
    CLS_ILL  = 3'd6
  } instr_cls_t;

endpackage
`default_nettype wire

// File: rtl/opcode_class_decoder.sv
`default_nettype none
// ============================================================================
// Module   : opcode_class_decoder
// Brief    : Combinational opcode -> instruction class lookup.
// Revision : 1.0 - initial release
// ============================================================================
module opcode_class_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter int OPC_W = OPC_WIDTH
) (
  input  logic [OPC_W-1:0] opcode,
  output instr_cls_t       cls
);

  always_comb begin
    cls = CLS_ILL;
    case (opcode)
      OPC_RTYPE: cls = CLS_R;
      OPC_LD:    cls = CLS_LD;
      OPC_ADDI:  cls = CLS_ADDI;
      OPC_SD:    cls = CLS_SD;
      OPC_BR:    cls = CLS_BR;
      default:   cls = CLS_ILL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_fsm
// Brief    : FETCH/DECODE/EXEC/MEM/WB sequencer with memory-ready stall and
//            retired-instruction counter. ILLEGAL_TRAP_EN makes illegal
//            opcodes trap instead of retiring as NOPs.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int OPC_W = OPC_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic             reg_write,
  output logic [1:0]       alu_op,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_retired,
  output logic             illegal
);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  instr_cls_t       r_cls;
  instr_cls_t       w_dec_cls;
  logic [CNT_W-1:0] r_cnt;

  logic       w_ir_write, w_pc_write, w_branch, w_mem_read, w_mem_write;
  logic       w_mem_to_reg, w_alu_src, w_reg_write;
  logic [1:0] w_alu_op;

  opcode_class_decoder #(.OPC_W(OPC_W)) u_dec (
    .opcode (opcode),
    .cls    (w_dec_cls)
  );

  // The class is captured only in DECODE; later opcode changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cls   <= CLS_NOP;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_cls <= w_dec_cls;
      if (pc_write)            r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (w_dec_cls == CLS_ILL) begin
`ifdef ILLEGAL_TRAP_EN
          w_next = S_TRAP;
`else
          w_next = S_FETCH;
`endif
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (r_cls)
          CLS_R, CLS_ADDI: w_next = S_WB;
          CLS_LD, CLS_SD:  w_next = S_MEM;
          default:         w_next = S_FETCH;
        endcase
      end
      S_MEM:    if (mem_ready) w_next = (r_cls == CLS_LD) ? S_WB : S_FETCH;
      S_WB:     w_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   w_next = S_TRAP;
`endif
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src    = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_op     = ALUOP_ADD;
    case (r_state)
      S_FETCH:  w_ir_write = 1'b1;
      S_DECODE: begin
`ifndef ILLEGAL_TRAP_EN
        w_pc_write = (w_dec_cls == CLS_ILL);
`endif
      end
      S_EXEC: begin
        case (r_cls)
          CLS_R:                    w_alu_op = ALUOP_FUNCT;
          CLS_ADDI, CLS_LD, CLS_SD: w_alu_src = 1'b1;
          CLS_BR: begin
            w_alu_op   = ALUOP_BR;
            w_branch   = 1'b1;
            w_pc_write = 1'b1;
          end
          default: ;
        endcase
      end
      // Request held every cycle until the memory signals completion.
      S_MEM: begin
        w_alu_src   = 1'b1;
        w_mem_read  = (r_cls == CLS_LD);
        w_mem_write = (r_cls == CLS_SD);
        w_pc_write  = (r_cls == CLS_SD) && mem_ready;
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_pc_write   = 1'b1;
        w_mem_to_reg = (r_cls == CLS_LD);
      end
      default: ;
    endcase
  end

  assign ir_write      = w_ir_write   & ~reset;
  assign pc_write      = w_pc_write   & ~reset;
  assign branch        = w_branch     & ~reset;
  assign mem_read      = w_mem_read   & ~reset;
  assign mem_write     = w_mem_write  & ~reset;
  assign mem_to_reg    = w_mem_to_reg & ~reset;
  assign alu_src       = w_alu_src    & ~reset;
  assign reg_write     = w_reg_write  & ~reset;
  assign alu_op        = reset ? 2'b00 : w_alu_op;
  assign state         = r_state;
  assign instr_retired = r_cnt;

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk) begin
    if (reset)
      r_illegal <= 1'b0;
    else if (r_state == S_DECODE && w_dec_cls == CLS_ILL)
      r_illegal <= 1'b1;
  end

  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl_fsm
// Brief    : Directed vector table plus reset/illegal/wrap sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic        mem_ready = 1'b0;
  logic        ir_write, pc_write, branch, mem_read, mem_write;
  logic        mem_to_reg, alu_src, reg_write;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] instr_retired;
  logic        illegal;

  logic        ir_write4, pc_write4, branch4, mem_read4, mem_write4;
  logic        mem_to_reg4, alu_src4, reg_write4;
  logic [1:0]  alu_op4;
  logic [2:0]  state4;
  logic [3:0]  instr_retired4;
  logic        illegal4;

  int n_tests = 0;
  int n_fail  = 0;
  int inv_err = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .reg_write(reg_write), .alu_op(alu_op),
    .state(state), .instr_retired(instr_retired), .illegal(illegal)
  );

  multicycle_ctrl_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .ir_write(ir_write4), .pc_write(pc_write4), .branch(branch4),
    .mem_read(mem_read4), .mem_write(mem_write4), .mem_to_reg(mem_to_reg4),
    .alu_src(alu_src4), .reg_write(reg_write4), .alu_op(alu_op4),
    .state(state4), .instr_retired(instr_retired4), .illegal(illegal4)
  );

  // {ir_write, pc_write, branch, mem_read, mem_write, mem_to_reg, alu_src, reg_write, alu_op}
  logic [9:0] ctl;
  assign ctl = {ir_write, pc_write, branch, mem_read, mem_write,
                mem_to_reg, alu_src, reg_write, alu_op};

  localparam logic [9:0] CT_NONE   = 10'b0000000000;
  localparam logic [9:0] CT_FETCH  = 10'b1000000000;
  localparam logic [9:0] CT_PC     = 10'b0100000000;
  localparam logic [9:0] CT_EXR    = 10'b0000000010;
  localparam logic [9:0] CT_EXI    = 10'b0000001000;
  localparam logic [9:0] CT_WBR    = 10'b0100000100;
  localparam logic [9:0] CT_MEMLD  = 10'b0001001000;
  localparam logic [9:0] CT_WBLD   = 10'b0100010100;
  localparam logic [9:0] CT_SDDONE = 10'b0100101000;
  localparam logic [9:0] CT_BR     = 10'b0110000001;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       mr;
    logic [2:0] st;
    logic [9:0] ctl;
    int         cnt;
  } vec_t;

  vec_t vecs[21];

  always @(negedge clk) if (reg_write && mem_write) inv_err++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change just after the edge; outputs are sampled on the falling edge.
  task automatic drive(input logic r, input logic [6:0] o, input logic m);
    @(posedge clk);
    #1;
    reset = r;
    opcode = o;
    mem_ready = m;
    @(negedge clk);
  endtask

  initial begin
    int pulses;

    // R-type, ld with 3 wait states, sd (ready at once), beq back to back
    vecs[0]  = '{1'b1, 7'd0,  1'b0, 3'd0, CT_NONE,   0};
    vecs[1]  = '{1'b0, 7'd51, 1'b0, 3'd0, CT_FETCH,  0};
    vecs[2]  = '{1'b0, 7'd51, 1'b0, 3'd1, CT_NONE,   0};
    vecs[3]  = '{1'b0, 7'd51, 1'b0, 3'd2, CT_EXR,    0};
    vecs[4]  = '{1'b0, 7'd51, 1'b0, 3'd4, CT_WBR,    0};
    vecs[5]  = '{1'b0, 7'd3,  1'b1, 3'd0, CT_FETCH,  1};
    vecs[6]  = '{1'b0, 7'd3,  1'b1, 3'd1, CT_NONE,   1};
    vecs[7]  = '{1'b0, 7'd3,  1'b1, 3'd2, CT_EXI,    1};
    vecs[8]  = '{1'b0, 7'd3,  1'b0, 3'd3, CT_MEMLD,  1};
    vecs[9]  = '{1'b0, 7'd3,  1'b0, 3'd3, CT_MEMLD,  1};
    vecs[10] = '{1'b0, 7'd3,  1'b0, 3'd3, CT_MEMLD,  1};
    vecs[11] = '{1'b0, 7'd3,  1'b1, 3'd3, CT_MEMLD,  1};
    vecs[12] = '{1'b0, 7'd3,  1'b0, 3'd4, CT_WBLD,   1};
    vecs[13] = '{1'b0, 7'd35, 1'b1, 3'd0, CT_FETCH,  2};
    vecs[14] = '{1'b0, 7'd35, 1'b1, 3'd1, CT_NONE,   2};
    vecs[15] = '{1'b0, 7'd35, 1'b1, 3'd2, CT_EXI,    2};
    vecs[16] = '{1'b0, 7'd35, 1'b1, 3'd3, CT_SDDONE, 2};
    vecs[17] = '{1'b0, 7'd99, 1'b0, 3'd0, CT_FETCH,  3};
    vecs[18] = '{1'b0, 7'd99, 1'b0, 3'd1, CT_NONE,   3};
    vecs[19] = '{1'b0, 7'd51, 1'b0, 3'd2, CT_BR,     3};
    vecs[20] = '{1'b0, 7'd51, 1'b0, 3'd0, CT_FETCH,  4};

    drive(1'b1, 7'd0, 1'b0);
    drive(1'b1, 7'd0, 1'b0);
    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].mr);
      chk($sformatf("row%0d state", i), 64'(state), 64'(vecs[i].st));
      chk($sformatf("row%0d ctl", i), 64'(ctl), 64'(vecs[i].ctl));
      chk($sformatf("row%0d count", i), 64'(instr_retired), 64'(vecs[i].cnt));
      chk($sformatf("row%0d count4", i), 64'(instr_retired4), 64'(vecs[i].cnt));
    end

    // Reset while a load is stalled in MEM
    drive(1'b1, 7'd3, 1'b0);
    drive(1'b0, 7'd3, 1'b0);
    drive(1'b0, 7'd3, 1'b0);
    drive(1'b0, 7'd3, 1'b0);
    drive(1'b0, 7'd3, 1'b0);
    chk("rstmem stalled state", 64'(state), 64'd3);
    chk("rstmem stalled mem_read", 64'(mem_read), 64'd1);
    drive(1'b1, 7'd3, 1'b0);
    chk("rstmem during reset ctl", 64'(ctl), 64'(CT_NONE));
    drive(1'b0, 7'd3, 1'b0);
    chk("rstmem after state", 64'(state), 64'd0);
    chk("rstmem after count", 64'(instr_retired), 64'd0);
    chk("rstmem after ctl", 64'(ctl), 64'(CT_FETCH));

    // Illegal opcode
    drive(1'b1, 7'h7F, 1'b0);
    drive(1'b0, 7'h7F, 1'b0);
    drive(1'b0, 7'h7F, 1'b0);
    chk("ill decode state", 64'(state), 64'd1);
`ifdef ILLEGAL_TRAP_EN
    chk("ill decode ctl", 64'(ctl), 64'(CT_NONE));
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, (c % 2 == 0) ? 7'd51 : 7'd3, 1'b1);
      chk($sformatf("trap%0d state", c), 64'(state), 64'd5);
      chk($sformatf("trap%0d ctl", c), 64'(ctl), 64'(CT_NONE));
      chk($sformatf("trap%0d illegal", c), 64'(illegal), 64'd1);
      chk($sformatf("trap%0d count", c), 64'(instr_retired), 64'd0);
    end
    drive(1'b1, 7'd0, 1'b0);
    drive(1'b0, 7'd0, 1'b0);
    chk("trap cleared state", 64'(state), 64'd0);
    chk("trap cleared illegal", 64'(illegal), 64'd0);
`else
    chk("ill decode ctl", 64'(ctl), 64'(CT_PC));
    drive(1'b0, 7'd51, 1'b0);
    chk("ill next state", 64'(state), 64'd0);
    chk("ill count", 64'(instr_retired), 64'd1);
    chk("ill flag", 64'(illegal), 64'd0);
`endif

    // Sixteen addi instructions wrap the 4-bit counter
    drive(1'b1, 7'd19, 1'b0);
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      for (int c = 0; c < 4; c++) begin
        drive(1'b0, 7'd19, 1'b0);
        if (pc_write) pulses++;
        if (k == 0 && c == 2) chk("addi exec ctl", 64'(ctl), 64'(CT_EXI));
        if (k == 0 && c == 3) chk("addi wb ctl", 64'(ctl), 64'(CT_WBR));
        if (k == 15 && c == 3) chk("wrap pre count4", 64'(instr_retired4), 64'd15);
      end
    end
    drive(1'b0, 7'd19, 1'b0);
    chk("wrap count4", 64'(instr_retired4), 64'd0);
    chk("wrap count32", 64'(instr_retired), 64'd16);
    chk("wrap pc pulses", 64'(pulses), 64'd16);
    chk("wrap state", 64'(state), 64'd0);

    chk("inv reg_write&mem_write", 64'(inv_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
